mux4_rr_arbiter: RTL

Round-robin arbiter and sequencer for the 4-to-1 mux datapath. It shares one output channel between four requesters and drives the mux select from a registered one-hot grant. Each accepted word is handed off with a valid/ready handshake. It sits directly in front of the 4:1 mux and replaces a free-running select with fair, handshaked access.

---
 rtl/mux4_rr_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter for four requesters with a registered one-hot grant and valid/ready hand-off.
// Optional ARB_LOCK_EN: a requester holding lock[sel] at transfer keeps the grant for a burst.
module mux4_rr_arbiter #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] data_in,
  input  logic [3:0]      lock,
  input  logic            out_ready,
  output logic [3:0]      gnt,
  output logic [1:0]      sel,
  output logic [DW-1:0]   out_data,
  output logic            out_valid
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_r;
  logic [1:0] ptr_r;
  logic [1:0] sel_r;
  logic [3:0] gnt_r;
  logic       valid_r;

  logic       xfer_s;
  logic       lock_hold_s;
  logic [3:0] cand_s;
  logic [1:0] base_s;
  logic [2:0] win_s;

  // Returns {found, index}; the search starts just after base and wraps back to base itself.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = base + k[1:0];
      if (cand[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign xfer_s = valid_r & out_ready;

`ifdef ARB_LOCK_EN
  assign lock_hold_s = lock[sel_r];
`else
  logic unused_lock_s;
  assign unused_lock_s = ^lock;
  assign lock_hold_s   = 1'b0;
`endif

  // Candidate set: every request when idle; after a transfer the served requester sits out one round
  always_comb begin
    cand_s = req;
    base_s = ptr_r;
    if (state_r == GRANT) begin
      cand_s = req & ~gnt_r;
      base_s = sel_r;
    end else begin
      cand_s = req;
      base_s = ptr_r;
    end
    win_s = rr_pick(cand_s, base_s);
  end

  // Arbitration state machine holding the registered grant, select, valid and pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 2'd3;
      sel_r   <= 2'd0;
      gnt_r   <= 4'b0000;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_s[2]) begin
            state_r <= GRANT;
            gnt_r   <= 4'b0001 << win_s[1:0];
            sel_r   <= win_s[1:0];
            valid_r <= 1'b1;
          end else begin
            gnt_r   <= 4'b0000;
            valid_r <= 1'b0;
          end
        end
        GRANT: begin
          if (xfer_s && !lock_hold_s) begin
            ptr_r <= sel_r;
            if (win_s[2]) begin
              gnt_r <= 4'b0001 << win_s[1:0];
              sel_r <= win_s[1:0];
            end else begin
              state_r <= IDLE;
              gnt_r   <= 4'b0000;
              valid_r <= 1'b0;
            end
          end else if (!xfer_s && !req[sel_r]) begin
            // Holder withdrew before hand-off: release without moving the pointer
            state_r <= IDLE;
            gnt_r   <= 4'b0000;
            valid_r <= 1'b0;
          end else begin
            state_r <= GRANT;
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= 4'b0000;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign sel       = sel_r;
  assign out_valid = valid_r;
  assign out_data  = data_in[sel_r*DW +: DW];

endmodule
